move_scheduler: RTL and testbench
=================================

// Module: move_scheduler
// PURPOSE
//  Sequences the tetrimino engine: detects player key presses, queues them, generates the gravity tick and
//  feeds one move command at a time over a valid/ready handshake. Sits between keypad decode and the engine
//  FSM; it is the only source of fall/left/right/rotate requests. Tracks level from row deletions.
// PARAMETERS
//  QDEPTH          4   key-move queue entries (power of 2, >=2)
//  BASE_PERIOD     30  gravity period in frames at level 0
//  STEP            2   frames removed from period per level
//  MIN_PERIOD      4   gravity period floor
//  SOFT_PERIOD     2   gravity period while soft-drop held
//  LINES_PER_LEVEL 10  deleted rows per level increment
// PORTS
//  vsync        in  1  clock, one rising edge per video frame
//  rst_n        in  1  async active-low reset
//  game_active  in  1  engine out of stop/default state
//  btn_op       in  4  key code: 0 none,1 left,2 right,3 rotate,4 pause,5 soft drop
//  cmd_valid    out 1  command offered to engine
//  cmd_op       out 2  0 FALL,1 LEFT,2 RIGHT,3 ROTATE
//  cmd_ready    in  1  engine accepts command this edge
//  piece_locked in  1  1-frame pulse: active piece locked, new piece spawning
//  row_deleted  in  1  1-frame pulse per deleted row
//  paused       out 1  pause state
//  level        out 4  current level, saturates at 15
//  overflow_cnt out 8  presses dropped on full queue, saturating
// BEHAVIOUR
//  Reset (async): cmd_valid=0, cmd_op=0, paused=0, level=0, overflow_cnt=0; queue empty; frame_cnt=0;
//   grav_pend=0; row_cnt=0; prev_op=0; FSM=IDLE.
//  FSM: IDLE -(game_active)-> RUN; RUN -(press 4)-> PAUSED; PAUSED -(press 4)-> RUN;
//   any state -(!game_active)-> IDLE, synchronously clearing everything to reset values, incl. cmd_valid
//   (sole exception to the hold rule).
//  Press = btn_op!=prev_op && btn_op!=0; prev_op registered every edge. Codes 6..15 ignored.
//  RUN: press 1/2/3 enqueues op; full queue -> press dropped, overflow_cnt+1 (sat 255). Full queue with
//   a pop on the same edge accepts the push.
//  Gravity: period = soft(btn_op==5) ? SOFT_PERIOD : max(MIN_PERIOD, BASE_PERIOD-level*STEP).
//   frame_cnt+1 each RUN edge; at frame_cnt>=period-1 -> frame_cnt=0, grav_pend=1. Ticks coalesce.
//  Issue (RUN, cmd_valid=0 or handshake this edge): grav_pend -> FALL, clear grav_pend; else queue
//   non-empty -> pop head; else cmd_valid=0. Command registered; visible next edge. Back-to-back allowed.
//  Hold: cmd_valid=1 keeps cmd_op stable until cmd_ready; never withdrawn (except !game_active).
//  piece_locked: queue flushed, grav_pend=0, frame_cnt=0; an outstanding command stays valid.
//   A same-edge handshake completes normally; no new command issues on that edge.
//  row_deleted: row_cnt+1; at LINES_PER_LEVEL -> row_cnt=0, level+1 (sat 15; row_cnt still wraps).
//  PAUSED: frame_cnt frozen, no issue, presses 1/2/3/5 ignored, outstanding command held until accepted.
//  Width rule: period math in 8-bit unsigned, clamped before compare; level*STEP never wraps.
// CONFIGURATION
//  AUTOREPEAT_EN defined: left/right held (btn_op stable at 1/2) for DAS_FRAMES=10 frames re-enqueues
//   the op every ARR_FRAMES=3 frames while held; counter resets on any btn_op change, pause or lock.
//   Enqueues obey the full/overflow rule.
//  Undefined: only edges enqueue; no repeat counter logic present.
// STRUCTURE
//  Package tetris_sched_pkg: cmd_op codes (CMD_FALL..CMD_ROTATE), key codes (KEY_LEFT..KEY_SOFT),
//   FSM state encoding (ST_IDLE/ST_RUN/ST_PAUSED).
//  One sub-module: move_fifo (QDEPTH x 2 bit, push/pop/flush, full/empty, same-edge push+pop when full).
// TESTING
//  1 reset mid-run: rst_n low with cmd_valid=1 -> all outputs 0 immediately, IDLE after release.
//  2 game_active=1, cmd_ready=1, no keys, level 0 -> FALL every 30 frames; 10 row_deleted -> every 28.
//  3 press left,right,rotate in 3 frames, cmd_ready=0 -> cmd_valid held on LEFT; release -> L,R,ROT in order.
//  4 cmd_ready=0, 6 alternating presses -> queue 4 (+1 outstanding), overflow_cnt=1; grav tick jumps queue.
//  5 press 4, wait 100 frames -> no cmd, frame_cnt frozen; press 4 -> gravity resumes at frozen count.
//  6 queue 3 entries, piece_locked -> queue empty, next FALL after full period; AUTOREPEAT_EN: hold 1
//   for 20 frames -> LEFT at frames 0,10,13,16,19.

Source files
------------

// File: rtl/tetris_sched_pkg.sv
// tetris_sched_pkg: command codes, key codes and FSM encoding shared by the move scheduler
package tetris_sched_pkg;
   localparam logic [1:0] CMD_FALL   = 2'd0;
   localparam logic [1:0] CMD_LEFT   = 2'd1;
   localparam logic [1:0] CMD_RIGHT  = 2'd2;
   localparam logic [1:0] CMD_ROTATE = 2'd3;
   localparam logic [3:0] KEY_NONE   = 4'd0;
   localparam logic [3:0] KEY_LEFT   = 4'd1;
   localparam logic [3:0] KEY_RIGHT  = 4'd2;
   localparam logic [3:0] KEY_ROTATE = 4'd3;
   localparam logic [3:0] KEY_PAUSE  = 4'd4;
   localparam logic [3:0] KEY_SOFT   = 4'd5;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED} state_t;
endpackage

// File: rtl/move_fifo.sv
// move_fifo: DEPTH x 2-bit move queue with flush; a pop lets a push into a full queue on the same edge
//   i_clk/i_rst_n  clock, async active-low reset
//   i_push/i_din   enqueue request and data
//   i_pop/o_dout   dequeue request and head entry
//   i_flush        empties the queue (wins over push/pop)
//   o_full/o_empty occupancy flags
module move_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  logic [1:0] i_din,
   output logic [1:0] o_dout,
   output logic       o_full,
   output logic       o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0] r_cnt;
   logic        w_wr, w_rd;

   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign o_empty = r_cnt == '0;
   assign w_rd    = i_pop && !o_empty;
   assign w_wr    = i_push && (!o_full || w_rd);
   assign o_dout  = r_mem[r_rd];

   always_ff @(posedge i_clk)
      if (w_wr && !i_flush) r_mem[r_wr] <= i_din;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         r_wr  <= w_wr ? r_wr + 1'b1 : r_wr;
         r_rd  <= w_rd ? r_rd + 1'b1 : r_rd;
         r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
   end
endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: turns key presses and gravity ticks into a one-at-a-time move command stream
//   i_vsync/i_rst_n   frame clock (one edge per frame), async active-low reset
//   i_game_active     engine running; low synchronously clears the scheduler
//   i_btn_op          key code: 0 none,1 left,2 right,3 rotate,4 pause,5 soft drop
//   o_cmd_valid/o_cmd_op/i_cmd_ready  command handshake: 0 fall,1 left,2 right,3 rotate
//   i_piece_locked    flushes queued moves and restarts the gravity period
//   i_row_deleted     one pulse per cleared row; every LINES_PER_LEVEL rows bump o_level
//   o_paused, o_level, o_overflow_cnt  status
//   Build option: define AUTOREPEAT_EN for held left/right auto-repeat
module move_scheduler
   import tetris_sched_pkg::*;
#(
   parameter int QDEPTH          = 4,
   parameter int BASE_PERIOD     = 30,
   parameter int STEP            = 2,
   parameter int MIN_PERIOD      = 4,
   parameter int SOFT_PERIOD     = 2,
   parameter int LINES_PER_LEVEL = 10
) (
   input  logic       i_vsync,
   input  logic       i_rst_n,
   input  logic       i_game_active,
   input  logic [3:0] i_btn_op,
   output logic       o_cmd_valid,
   output logic [1:0] o_cmd_op,
   input  logic       i_cmd_ready,
   input  logic       i_piece_locked,
   input  logic       i_row_deleted,
   output logic       o_paused,
   output logic [3:0] o_level,
   output logic [7:0] o_overflow_cnt
);
   state_t     r_state;
   logic [3:0] r_prev_op;
   logic [7:0] r_frame_cnt;
   logic       r_grav_pend;
   logic [3:0] r_row_cnt;
   logic       w_run, w_press, w_move, w_rep, w_push, w_pop, w_issue, w_hs, w_tick, w_full, w_empty;
   logic [1:0] w_head, w_din;
   logic [7:0] w_lvl_step, w_period;

   assign w_run      = r_state == ST_RUN && i_game_active;
   assign w_press    = i_btn_op != r_prev_op && i_btn_op != KEY_NONE;
   assign w_move     = i_btn_op == KEY_LEFT || i_btn_op == KEY_RIGHT || i_btn_op == KEY_ROTATE;
   assign w_din      = i_btn_op == KEY_LEFT ? CMD_LEFT : i_btn_op == KEY_RIGHT ? CMD_RIGHT : CMD_ROTATE;
   assign w_hs       = o_cmd_valid && i_cmd_ready;
   // a lock edge may complete a handshake but never starts a new command
   assign w_issue    = w_run && !i_piece_locked && (!o_cmd_valid || i_cmd_ready);
   assign w_pop      = w_issue && !r_grav_pend && !w_empty;
   assign w_push     = w_run && !i_piece_locked && ((w_press && w_move) || w_rep);
   assign w_lvl_step = 8'(o_level) * 8'(STEP);
   // clamp before subtracting so the 8-bit period never wraps
   assign w_period   = i_btn_op == KEY_SOFT ? 8'(SOFT_PERIOD) :
                       w_lvl_step + 8'(MIN_PERIOD) > 8'(BASE_PERIOD) ? 8'(MIN_PERIOD) :
                       8'(BASE_PERIOD) - w_lvl_step;
   assign w_tick     = r_frame_cnt >= w_period - 8'd1;

`ifdef AUTOREPEAT_EN
   localparam int DAS_FRAMES = 10;
   localparam int ARR_FRAMES = 3;
   logic [4:0] r_rep_cnt;
   logic       w_hold;
   assign w_hold = w_run && !i_piece_locked && i_btn_op == r_prev_op &&
                   (i_btn_op == KEY_LEFT || i_btn_op == KEY_RIGHT);
   // after each repeat the counter restarts ARR_FRAMES short of the threshold
   assign w_rep  = w_hold && r_rep_cnt + 5'd1 == 5'(DAS_FRAMES);
   always_ff @(posedge i_vsync or negedge i_rst_n)
      if (!i_rst_n) r_rep_cnt <= '0;
      else r_rep_cnt <= !w_hold ? 5'd0 : w_rep ? 5'(DAS_FRAMES - ARR_FRAMES) : r_rep_cnt + 5'd1;
`else
   assign w_rep = 1'b0;
`endif

   move_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .i_clk   (i_vsync),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_piece_locked || !i_game_active),
      .i_din   (w_din),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge i_vsync or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_prev_op      <= '0;
         r_frame_cnt    <= '0;
         r_grav_pend    <= 1'b0;
         r_row_cnt      <= '0;
         o_cmd_valid    <= 1'b0;
         o_cmd_op       <= CMD_FALL;
         o_paused       <= 1'b0;
         o_level        <= '0;
         o_overflow_cnt <= '0;
      end else if (!i_game_active) begin
         r_state        <= ST_IDLE;
         r_prev_op      <= '0;
         r_frame_cnt    <= '0;
         r_grav_pend    <= 1'b0;
         r_row_cnt      <= '0;
         o_cmd_valid    <= 1'b0;
         o_cmd_op       <= CMD_FALL;
         o_paused       <= 1'b0;
         o_level        <= '0;
         o_overflow_cnt <= '0;
      end else begin
         r_prev_op <= i_btn_op;
         if (r_state == ST_IDLE) r_state <= ST_RUN;
         else if (w_press && i_btn_op == KEY_PAUSE) begin
            r_state  <= r_state == ST_RUN ? ST_PAUSED : ST_RUN;
            o_paused <= r_state == ST_RUN;
         end
         if (i_piece_locked) begin
            r_frame_cnt <= '0;
            r_grav_pend <= 1'b0;
         end else if (w_run) begin
            r_frame_cnt <= w_tick ? 8'd0 : r_frame_cnt + 8'd1;
            r_grav_pend <= w_tick || (r_grav_pend && !w_issue);
         end
         if (w_issue) begin
            o_cmd_valid <= r_grav_pend || !w_empty;
            o_cmd_op    <= r_grav_pend ? CMD_FALL : w_empty ? o_cmd_op : w_head;
         end else if (w_hs) o_cmd_valid <= 1'b0;
         if (w_push && w_full && !w_pop && o_overflow_cnt != 8'hFF) o_overflow_cnt <= o_overflow_cnt + 8'd1;
         if (i_row_deleted) begin
            r_row_cnt <= r_row_cnt == 4'(LINES_PER_LEVEL - 1) ? 4'd0 : r_row_cnt + 4'd1;
            if (r_row_cnt == 4'(LINES_PER_LEVEL - 1) && o_level != 4'hF) o_level <= o_level + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed scenarios for the move scheduler with hand-computed command timing
module tb_move_scheduler;
   localparam logic [1:0] OP_F = 2'd0, OP_L = 2'd1, OP_R = 2'd2, OP_ROT = 2'd3;
   logic       vsync = 1'b0, rst_n = 1'b0, game_active = 1'b0, cmd_ready = 1'b0;
   logic       piece_locked = 1'b0, row_deleted = 1'b0;
   logic [3:0] btn_op = 4'd0;
   logic       cmd_valid, paused;
   logic [1:0] cmd_op;
   logic [3:0] level;
   logic [7:0] overflow_cnt;
   int         n_tests = 0, n_fail = 0, cyc = 0;
   logic [1:0] log_op[$];
   int         log_t[$];

   move_scheduler dut (
      .i_vsync        (vsync),
      .i_rst_n        (rst_n),
      .i_game_active  (game_active),
      .i_btn_op       (btn_op),
      .o_cmd_valid    (cmd_valid),
      .o_cmd_op       (cmd_op),
      .i_cmd_ready    (cmd_ready),
      .i_piece_locked (piece_locked),
      .i_row_deleted  (row_deleted),
      .o_paused       (paused),
      .o_level        (level),
      .o_overflow_cnt (overflow_cnt)
   );

   always #5 vsync = ~vsync;
   always @(posedge vsync) cyc <= cyc + 1;
   // records each handshake that the coming rising edge will complete, tagged with the edge count so far
   always @(negedge vsync) begin
      #1;
      if (rst_n && game_active && cmd_valid && cmd_ready) begin
         log_op.push_back(cmd_op);
         log_t.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge vsync);
   endtask

   // returns just after the first RUN-entering edge (E0)
   task automatic start_game(input logic rdy);
      game_active = 1'b0; btn_op = 4'd0; piece_locked = 1'b0; row_deleted = 1'b0; cmd_ready = rdy;
      tick(2);
      log_op.delete(); log_t.delete();
      game_active = 1'b1;
      tick(1);
   endtask

   task automatic test_reset;
      #3;
      n_tests++;
      if ({cmd_valid, cmd_op, paused, level, overflow_cnt} !== 16'h0) begin
         n_fail++; $display("FAIL reset_init: outputs=%h expected 0000", {cmd_valid, cmd_op, paused, level, overflow_cnt});
      end
      tick(1); rst_n = 1'b1;
      start_game(1'b0);
      tick(33);
      n_tests++;
      if (cmd_valid !== 1'b1 || cmd_op !== OP_F) begin
         n_fail++; $display("FAIL pre_reset_cmd: valid=%0b op=%0d expected valid=1 op=0", cmd_valid, cmd_op);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({cmd_valid, cmd_op, paused, level, overflow_cnt} !== 16'h0) begin
         n_fail++; $display("FAIL async_reset: outputs=%h expected 0000", {cmd_valid, cmd_op, paused, level, overflow_cnt});
      end
      tick(1); rst_n = 1'b1; game_active = 1'b0;
      tick(3);
      n_tests++;
      if (cmd_valid !== 1'b0 || paused !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_idle: valid=%0b paused=%0b expected 0 0", cmd_valid, paused);
      end
      start_game(1'b0);
      tick(33);
      game_active = 1'b0;
      tick(1);
      n_tests++;
      if (cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL inactive_clears_valid: valid=%0b expected 0", cmd_valid);
      end
   endtask

   task automatic test_gravity;
      int c0;
      start_game(1'b1);
      c0 = cyc;
      tick(95);
      n_tests++;
      if (log_t.size() != 3 || log_t[0] != c0 + 31 || log_t[1] - log_t[0] != 30 || log_t[2] - log_t[1] != 30) begin
         n_fail++; $display("FAIL gravity_l0: n=%0d first=%0d gaps=%0d,%0d expected n=3 first=%0d gaps=30,30",
                            log_t.size(), log_t[0] - c0, log_t[1] - log_t[0], log_t[2] - log_t[1], 31);
      end
      n_tests++;
      if (log_op.size() != 3 || log_op[0] !== OP_F || log_op[1] !== OP_F || log_op[2] !== OP_F) begin
         n_fail++; $display("FAIL gravity_ops: n=%0d ops=%0d,%0d,%0d expected 3 FALL(0)", log_op.size(), log_op[0], log_op[1], log_op[2]);
      end
      row_deleted = 1'b1;
      tick(9);
      n_tests++;
      if (level !== 4'd0) begin
         n_fail++; $display("FAIL level_9_rows: level=%0d expected 0", level);
      end
      tick(1);
      row_deleted = 1'b0;
      n_tests++;
      if (level !== 4'd1) begin
         n_fail++; $display("FAIL level_10_rows: level=%0d expected 1", level);
      end
      log_op.delete(); log_t.delete();
      tick(100);
      n_tests++;
      if (log_t.size() < 3 || log_t[2] - log_t[1] != 28) begin
         n_fail++; $display("FAIL gravity_l1: n=%0d gap=%0d expected gap=28", log_t.size(), log_t[2] - log_t[1]);
      end
   endtask

   task automatic test_soft_drop;
      start_game(1'b1);
      btn_op = 4'd5;
      tick(12);
      btn_op = 4'd0;
      n_tests++;
      if (log_t.size() < 3 || log_t[2] - log_t[1] != 2 || log_op[1] !== OP_F) begin
         n_fail++; $display("FAIL soft_period: n=%0d gap=%0d op=%0d expected gap=2 op=0", log_t.size(), log_t[2] - log_t[1], log_op[1]);
      end
   endtask

   task automatic test_queue_order;
      start_game(1'b0);
      btn_op = 4'd1; tick(1);
      btn_op = 4'd2; tick(1);
      btn_op = 4'd3; tick(1);
      btn_op = 4'd0; tick(3);
      n_tests++;
      if (cmd_valid !== 1'b1 || cmd_op !== OP_L || log_op.size() != 0) begin
         n_fail++; $display("FAIL hold_left: valid=%0b op=%0d accepted=%0d expected valid=1 op=1 accepted=0", cmd_valid, cmd_op, log_op.size());
      end
      cmd_ready = 1'b1;
      tick(5);
      n_tests++;
      if (log_op.size() != 3 || log_op[0] !== OP_L || log_op[1] !== OP_R || log_op[2] !== OP_ROT) begin
         n_fail++; $display("FAIL move_order: n=%0d ops=%0d,%0d,%0d expected 1,2,3", log_op.size(), log_op[0], log_op[1], log_op[2]);
      end
      n_tests++;
      if (log_t.size() != 3 || log_t[1] != log_t[0] + 1 || log_t[2] != log_t[1] + 1) begin
         n_fail++; $display("FAIL back_to_back: gaps=%0d,%0d expected 1,1", log_t[1] - log_t[0], log_t[2] - log_t[1]);
      end
      n_tests++;
      if (cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL drain_idle: valid=%0b expected 0", cmd_valid);
      end
   endtask

   task automatic test_overflow;
      logic [1:0] exp_ops [6];
      exp_ops = '{OP_L, OP_F, OP_R, OP_L, OP_R, OP_L};
      start_game(1'b0);
      for (int i = 0; i < 6; i++) begin
         btn_op = (i % 2 == 0) ? 4'd1 : 4'd2;
         tick(1);
      end
      btn_op = 4'd0;
      n_tests++;
      if (overflow_cnt !== 8'd1) begin
         n_fail++; $display("FAIL overflow_cnt: got %0d expected 1", overflow_cnt);
      end
      tick(34);
      n_tests++;
      if (cmd_valid !== 1'b1 || cmd_op !== OP_L) begin
         n_fail++; $display("FAIL held_through_tick: valid=%0b op=%0d expected valid=1 op=1", cmd_valid, cmd_op);
      end
      cmd_ready = 1'b1;
      tick(10);
      n_tests++;
      if (log_op.size() != 6) begin
         n_fail++; $display("FAIL overflow_drain_count: got %0d expected 6", log_op.size());
      end
      for (int i = 0; i < 6 && i < log_op.size(); i++) begin
         n_tests++;
         if (log_op[i] !== exp_ops[i]) begin
            n_fail++; $display("FAIL overflow_order[%0d]: got %0d expected %0d", i, log_op[i], exp_ops[i]);
         end
      end
   endtask

   task automatic test_pause;
      int c0;
      start_game(1'b1);
      tick(9);
      btn_op = 4'd4; tick(1);
      btn_op = 4'd0;
      n_tests++;
      if (paused !== 1'b1) begin
         n_fail++; $display("FAIL pause_enter: paused=%0b expected 1", paused);
      end
      tick(50);
      btn_op = 4'd1; tick(1);
      btn_op = 4'd0; tick(49);
      n_tests++;
      if (log_op.size() != 0 || cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL pause_silent: accepted=%0d valid=%0b expected 0 0", log_op.size(), cmd_valid);
      end
      c0 = cyc;
      btn_op = 4'd4; tick(1);
      btn_op = 4'd0;
      n_tests++;
      if (paused !== 1'b0) begin
         n_fail++; $display("FAIL pause_exit: paused=%0b expected 0", paused);
      end
      tick(24);
      n_tests++;
      if (log_op.size() != 1 || log_op[0] !== OP_F || log_t[0] != c0 + 22) begin
         n_fail++; $display("FAIL resume_frozen_count: n=%0d op=%0d at=%0d expected n=1 op=0 at=22",
                            log_op.size(), log_op[0], log_t[0] - c0);
      end
   endtask

   task automatic test_lock;
      int c0;
      start_game(1'b0);
      for (int i = 0; i < 4; i++) begin
         btn_op = (i % 2 == 0) ? 4'd1 : 4'd2;
         tick(1);
      end
      btn_op = 4'd0; tick(1);
      c0 = cyc;
      piece_locked = 1'b1; tick(1);
      piece_locked = 1'b0;
      n_tests++;
      if (cmd_valid !== 1'b1 || cmd_op !== OP_L) begin
         n_fail++; $display("FAIL lock_keeps_cmd: valid=%0b op=%0d expected valid=1 op=1", cmd_valid, cmd_op);
      end
      tick(4);
      cmd_ready = 1'b1;
      tick(36);
      n_tests++;
      if (log_op.size() != 2 || log_op[0] !== OP_L || log_op[1] !== OP_F || log_t[1] != c0 + 32) begin
         n_fail++; $display("FAIL lock_flush: n=%0d ops=%0d,%0d fall_at=%0d expected n=2 ops=1,0 fall_at=32",
                            log_op.size(), log_op[0], log_op[1], log_t[1] - c0);
      end
   endtask

`ifdef AUTOREPEAT_EN
   task automatic test_autorepeat;
      int c0;
      int exp_t [5];
      exp_t = '{2, 12, 15, 18, 21};
      start_game(1'b1);
      c0 = cyc;
      btn_op = 4'd1; tick(20);
      btn_op = 4'd0; tick(3);
      n_tests++;
      if (log_op.size() != 5) begin
         n_fail++; $display("FAIL repeat_count: got %0d expected 5", log_op.size());
      end
      for (int i = 0; i < 5 && i < log_op.size(); i++) begin
         n_tests++;
         if (log_op[i] !== OP_L || log_t[i] != c0 + exp_t[i]) begin
            n_fail++; $display("FAIL repeat[%0d]: op=%0d at=%0d expected op=1 at=%0d", i, log_op[i], log_t[i] - c0, exp_t[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_gravity;
      test_soft_drop;
      test_queue_order;
      test_overflow;
      test_pause;
      test_lock;
`ifdef AUTOREPEAT_EN
      test_autorepeat;
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
